float_to_pcm: RTL and testbench

Output stage directly downstream of the FIR filter top. Takes one `floatType` filter result per decimated sample period and converts it to signed fixed-point PCM with rounding and saturation. Results go into a small FIFO and leave through a valid/ready handshake. This is the point where the filter's floating-point datapath meets fixed-point consumers: DAC model, serial link, or testbench capture.

---
 rtl/float_to_pcm_pkg.sv | 13 +
 rtl/sync_fifo.sv | 45 ++++
 rtl/float_to_pcm.sv | 134 +++++++++++++
 tb/tb_float_to_pcm.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/float_to_pcm_pkg.sv
// Shared float format of the filter datapath and defaults for the PCM output stage.
package float_to_pcm_pkg;
    localparam int E_W       = 8;
    localparam int MANT_W    = 23;
    localparam int BIAS      = (1 << (E_W - 1)) - 1;
    localparam int OUT_W_DEF = 16;

    typedef struct packed {
        logic              sign;
        logic [E_W-1:0]    exp;
        logic [MANT_W-1:0] mant;
    } floatType;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers; head word is read straight from the register bank.
module sync_fifo #(
    parameter int Width = 16,
    parameter int Depth = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     wr_en,
    input  logic [Width-1:0]         wr_data,
    input  logic                     rd_en,
    output logic [Width-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(Depth):0]   count
);
    localparam int AW = $clog2(Depth);

    logic [Depth-1:0][Width-1:0] mem;
    logic [AW:0]                 wr_ptr, rd_ptr;
    logic                        do_wr, do_rd;

    assign empty   = (wr_ptr == rd_ptr);
    assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign count   = wr_ptr - rd_ptr;
    assign rd_data = mem[rd_ptr[AW-1:0]];

    // A pop frees the slot in the same edge, so a full FIFO can still accept
    assign do_rd = rd_en && !empty;
    assign do_wr = wr_en && (!full || do_rd);

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            mem    <= '0;
        end else begin
            if (do_wr) begin
                mem[wr_ptr[AW-1:0]] <= wr_data;
                wr_ptr              <= wr_ptr + 1'b1;
            end
            if (do_rd)
                rd_ptr <= rd_ptr + 1'b1;
        end
    end
endmodule

// File: rtl/float_to_pcm.sv
// Converts filter floats to rounded, saturated Q1.(Out_w-1) PCM through a 3-stage pipe and an output FIFO.
module float_to_pcm
    import float_to_pcm_pkg::*;
#(
    parameter int Out_w = OUT_W_DEF,
    parameter int Depth = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  floatType         in,
    input  logic             in_valid,
    output logic [Out_w-1:0] out,
    output logic             out_valid,
    input  logic             out_ready,
    output logic             sat,
    output logic             ovf,
    input  logic             flag_clr
);
    localparam int STAGES = 3;
    localparam int GW     = Out_w + 1;           // magnitude plus guard bit
    localparam int XW     = GW + MANT_W + 1;     // room for any in-range left shift
    localparam logic [Out_w:0] FS = (Out_w+1)'(1) << (Out_w - 1);

    logic [STAGES-1:0] vld_pipe;

    // S1: unpack and align so that bit 0 is the guard bit
    logic [XW-1:0] sig_x, shifted;
    logic [GW-1:0] mag_g_d;
    logic          big_d;
    int            t;

    always_comb begin
        sig_x   = XW'({1'b1, in.mant});
        t       = int'(in.exp) - BIAS + Out_w - MANT_W;
        shifted = '0;
        big_d   = 1'b0;
        if (in.exp != '0) begin
            if (t >= GW)
                big_d = 1'b1;
            else if (t >= 0)
                shifted = sig_x << t;
            else if (1 - t <= MANT_W + 2)
                shifted = sig_x >> (-t);
        end
        big_d   = big_d | (|shifted[XW-1:GW]);
        mag_g_d = shifted[GW-1:0];
    end

    logic          s1_sign, s1_big;
    logic [GW-1:0] s1_mag_g;

    always_ff @(posedge clk) begin
        s1_sign  <= in.sign;
        s1_big   <= big_d;
        s1_mag_g <= mag_g_d;
    end

    // S2: round half away from zero on the magnitude; sticky bits are dropped
    logic         s2_sign, s2_big;
    logic [Out_w:0] s2_mag;

    always_ff @(posedge clk) begin
        s2_sign <= s1_sign;
        s2_big  <= s1_big;
        s2_mag  <= {1'b0, s1_mag_g[GW-1:1]} + (Out_w+1)'(s1_mag_g[0]);
    end

    // S3: saturate and apply sign; -1.0 exactly fits the negative range
    logic [Out_w-1:0] pcm_d;
    logic [Out_w:0]   neg_mag;
    logic             clip_d;

    always_comb begin
        neg_mag = '0 - s2_mag;
        pcm_d   = s2_mag[Out_w-1:0];
        clip_d  = 1'b0;
        if (!s2_sign) begin
            if (s2_big || s2_mag >= FS) begin
                pcm_d  = {1'b0, {(Out_w-1){1'b1}}};
                clip_d = 1'b1;
            end
        end else if (s2_big || s2_mag > FS) begin
            pcm_d  = {1'b1, {(Out_w-1){1'b0}}};
            clip_d = 1'b1;
        end else begin
            pcm_d  = neg_mag[Out_w-1:0];
        end
    end

    logic [Out_w-1:0] s3_pcm;
    logic             s3_clip;

    always_ff @(posedge clk) begin
        s3_pcm  <= pcm_d;
        s3_clip <= clip_d;
    end

    always_ff @(posedge clk) begin
        if (rst) vld_pipe <= '0;
        else     vld_pipe <= {vld_pipe[STAGES-2:0], in_valid};
    end

    logic                    fifo_full, fifo_empty, pop, drop;
    logic [$clog2(Depth):0]  fifo_count;
    logic                    unused_count;

    sync_fifo #(.Width(Out_w), .Depth(Depth)) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (vld_pipe[STAGES-1]),
        .wr_data (s3_pcm),
        .rd_en   (pop),
        .rd_data (out),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_count)
    );

    assign unused_count = ^fifo_count;
    assign out_valid    = !fifo_empty;
    assign pop          = out_valid && out_ready;
    assign drop         = vld_pipe[STAGES-1] && fifo_full && !pop;

    // A new event outranks a clear in the same cycle
    always_ff @(posedge clk) begin
        if (rst) begin
            sat <= 1'b0;
            ovf <= 1'b0;
        end else begin
            sat <= (sat && !flag_clr) || (vld_pipe[STAGES-1] && s3_clip);
            ovf <= (ovf && !flag_clr) || drop;
        end
    end
endmodule

// File: tb/tb_float_to_pcm.sv
// Directed and random checks of float_to_pcm against a real-arithmetic reference model.
module tb_float_to_pcm;
    import float_to_pcm_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    floatType    in  = '0;
    logic        in_valid  = 1'b0;
    logic [15:0] out;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        sat, ovf;
    logic        flag_clr  = 1'b0;

    int errors = 0;
    int checks = 0;

    float_to_pcm #(.Out_w(16), .Depth(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in        (in),
        .in_valid  (in_valid),
        .out       (out),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .sat       (sat),
        .ovf       (ovf),
        .flag_clr  (flag_clr)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic signed [31:0] obs, input logic signed [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s: got %0d expected %0d", tag, obs, expv);
        end
    endtask

    function automatic floatType mkf(input bit s, input int e, input int m);
        floatType f;
        f.sign = s;
        f.exp  = 8'(e);
        f.mant = 23'(m);
        return f;
    endfunction

    function automatic real p2(input int k);
        real r = 1.0;
        if (k >= 0) repeat (k) r = r * 2.0;
        else        repeat (-k) r = r / 2.0;
        return r;
    endfunction

    // round(|x| * 2^15) half away from zero, then clip to the 16-bit signed range
    function automatic int model(input floatType f, output bit clip);
        real v, m;
        clip = 1'b0;
        if (f.exp == 0) return 0;
        v = (1.0 + real'(f.mant) / p2(23)) * p2(int'(f.exp) - 127 + 15);
        m = $floor(v + 0.5);
        if (!f.sign) begin
            if (m >= 32768.0) begin clip = 1'b1; return 32767; end
            return $rtoi(m);
        end
        if (m > 32768.0) begin clip = 1'b1; return -32768; end
        return -$rtoi(m);
    endfunction

    task automatic one(input string tag, input floatType f, input int expv);
        in = f; in_valid = 1'b1; tick(); in_valid = 1'b0;
        repeat (3) tick();
        chk({tag, "_vld"}, out_valid, 1);
        chk(tag, $signed(out), expv);
        tick();
    endtask

    initial begin
        int  q[$];
        bit  cl, any_clip, seen;
        floatType f;

        repeat (3) tick();
        rst = 1'b0;
        chk("rst_out", $signed(out), 0);
        chk("rst_vld", out_valid, 0);
        chk("rst_sat", sat, 0);
        chk("rst_ovf", ovf, 0);

        // basic values, latency and consecutive output
        out_ready = 1'b1;
        in = mkf(0, 126, 0); in_valid = 1'b1; tick();
        in = mkf(1, 125, 0); tick();
        in = mkf(0, 0, 0);   tick();
        in_valid = 1'b0;
        chk("lat_early", out_valid, 0);
        tick();
        chk("lat_vld", out_valid, 1);
        chk("half", $signed(out), 16384);
        tick(); chk("mquarter", $signed(out), -8192);
        tick(); chk("zero", $signed(out), 0);
        tick(); chk("empty1", out_valid, 0);
        chk("sat0", sat, 0);

        // saturation
        in = mkf(0, 127, 0); in_valid = 1'b1; tick();
        in = mkf(1, 127, 0); tick();
        in = mkf(0, 128, 'h6CCCCD); tick();
        in_valid = 1'b0;
        chk("sat_before", sat, 0);
        tick();
        chk("one", $signed(out), 32767);
        chk("sat_rise", sat, 1);
        tick(); chk("mone", $signed(out), -32768);
        tick(); chk("big", $signed(out), 32767);
        flag_clr = 1'b1; tick(); flag_clr = 1'b0;
        chk("sat_clr", sat, 0);

        // rounding
        one("r_p16",  mkf(0, 111, 0), 1);
        one("r_m16",  mkf(1, 111, 0), -1);
        one("r_p17",  mkf(0, 110, 0), 0);
        one("r_1p5",  mkf(0, 112, 'h400000), 2);
        one("r_exp0", mkf(0, 0, 'h12345), 0);
        one("r_negz", mkf(1, 107, 0), 0);
        chk("r_sat", sat, 0);

        // overflow: six strobes into a stalled FIFO
        out_ready = 1'b0;
        in_valid = 1'b1;
        in = mkf(0, 112, 0);        tick();
        in = mkf(0, 113, 0);        tick();
        in = mkf(0, 113, 'h400000); tick();
        in = mkf(0, 114, 0);        tick();
        in = mkf(0, 114, 'h200000); tick();
        in = mkf(0, 114, 'h400000); tick();
        in_valid = 1'b0;
        repeat (3) tick();
        chk("ovf_set", ovf, 1);
        out_ready = 1'b1;
        chk("drain1", $signed(out), 1);
        tick(); chk("drain2", $signed(out), 2);
        tick(); chk("drain3", $signed(out), 3);
        tick(); chk("drain4", $signed(out), 4);
        tick(); chk("drain_end", out_valid, 0);

        // reset mid-flight discards samples and clears flags
        in = mkf(0, 127, 0); in_valid = 1'b1; tick();
        in = mkf(0, 126, 0); tick();
        in_valid = 1'b0; rst = 1'b1; tick(); rst = 1'b0;
        chk("mrst_out", $signed(out), 0);
        chk("mrst_vld", out_valid, 0);
        chk("mrst_sat", sat, 0);
        chk("mrst_ovf", ovf, 0);
        seen = 1'b0;
        repeat (6) begin tick(); if (out_valid !== 1'b0 || sat !== 1'b0) seen = 1'b1; end
        chk("mrst_none", seen, 0);

        // full FIFO with push and pop on the same edge
        out_ready = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            in = mkf(0, 112 + k, 0); tick();
        end
        in_valid = 1'b0;
        repeat (3) tick();
        in = mkf(0, 116, 0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        repeat (2) tick();
        chk("full_head", $signed(out), 1);
        out_ready = 1'b1;
        tick(); chk("full_s2", $signed(out), 2);
        tick(); chk("full_s4", $signed(out), 4);
        tick(); chk("full_s8", $signed(out), 8);
        tick(); chk("full_s16", $signed(out), 16);
        tick(); chk("full_end", out_valid, 0);
        chk("full_ovf", ovf, 0);

        // a clip on the same edge as flag_clr still sets sat
        flag_clr = 1'b1;
        in = mkf(0, 127, 0); in_valid = 1'b1; tick(); in_valid = 1'b0;
        repeat (3) tick();
        chk("clr_race", sat, 1);
        tick();
        chk("clr_after", sat, 0);
        flag_clr = 1'b0;
        tick();

        // random samples against the reference model
        any_clip = 1'b0;
        for (int c = 0; c < 400; c++) begin
            if (out_valid) begin
                if (q.size() == 0) chk("rnd_extra", out_valid, 0);
                else chk("rnd_data", $signed(out), q.pop_front());
            end
            in_valid = ($urandom_range(0, 2) != 0);
            if (in_valid) begin
                f.sign = 1'($urandom_range(0, 1));
                f.exp  = ($urandom_range(0, 9) == 0) ? 8'd0 : 8'($urandom_range(100, 140));
                f.mant = 23'($urandom);
                in = f;
                q.push_back(model(f, cl));
                any_clip |= cl;
            end
            tick();
        end
        in_valid = 1'b0;
        repeat (6) begin
            if (out_valid) begin
                if (q.size() == 0) chk("rnd_extra", out_valid, 0);
                else chk("rnd_data", $signed(out), q.pop_front());
            end
            tick();
        end
        chk("rnd_left", q.size(), 0);
        chk("rnd_sat", sat, any_clip);
        chk("rnd_ovf", ovf, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
